// File: rtl/game_sequencer.sv
// Flappy Bird game-flow controller: IDLE -> COUNTDOWN -> PLAY -> DYING -> OVER.
// Derives a one-Clk frame tick from VGA_VS, schedules pipe spawns with LFSR gap
// heights, sets scroll speed from score level and keeps a saturating BCD score.
module game_sequencer #(
  parameter int unsigned COUNTDOWN_FRAMES = 180,
  parameter int unsigned DEATH_FRAMES     = 60,
  parameter int unsigned SPAWN_BASE       = 120,
  parameter int unsigned SPAWN_STEP       = 16,
  parameter int unsigned GAP_MIN          = 80,
  parameter int unsigned SPEED_STEP_SCORE = 5,
  parameter int unsigned MAX_SPEED        = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       start,
  input  logic       collision,
  input  logic       pipe_passed,
  input  logic [1:0] speed_sel,
  output logic [1:0] state_num,
  output logic       frame_tick,
  output logic       run,
  output logic       endgame,
  output logic       spawn,
  output logic [9:0] spawn_gap_y,
  output logic [2:0] scroll_speed,
  output logic [3:0] countdown_digit,
  output logic [7:0] score
);

  localparam int unsigned CntW = 10;

  typedef enum logic [2:0] {StIdle, StCountdown, StPlay, StDying, StOver} state_e;

  state_e          state_q, state_d;
  logic [1:0]      vs_sync_q;
  logic            vs_prev_q;
  logic            frame_tick_q;
  logic            tick;
  logic            start_q;
  logic            start_rise;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] timer_q, timer_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [7:0]      score_q, score_d;
  logic [3:0]      pass_cnt_q, pass_cnt_d;
  logic [4:0]      level_q, level_d;
  logic [2:0]      speed_q, speed_d;
  logic [9:0]      gap_q, gap_d;
  logic            spawn_q, spawn_d;
  logic            run_q, run_d;
  logic            endgame_q, endgame_d;
  logic [1:0]      state_num_q, state_num_d;
  logic [3:0]      digit_q, digit_d;
  logic [5:0]      speed_sum;
  logic [2:0]      speed_tgt;
  logic [CntW-1:0] interval;

  assign tick       = vs_sync_q[1] & ~vs_prev_q;
  assign start_rise = start & ~start_q;

  assign speed_sum = 6'd1 + {4'd0, speed_sel} + {1'b0, level_q};
  assign speed_tgt = (speed_sum > 6'(MAX_SPEED)) ? 3'(MAX_SPEED) : speed_sum[2:0];
  // Spawn spacing shrinks with the speed in force when the pipe is launched
  assign interval  = 10'(SPAWN_BASE) - 10'(SPAWN_STEP) * {7'd0, speed_q - 3'd1};

  // VS resynchroniser, edge detector and start-key history
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_sync_q    <= 2'b00;
      vs_prev_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      // A key held through reset must not start a game
      start_q      <= 1'b1;
    end else begin
      vs_sync_q    <= {vs_sync_q[0], frame_clk};
      vs_prev_q    <= vs_sync_q[1];
      frame_tick_q <= tick;
      start_q      <= start;
    end
  end

  // Game state, counters, score and registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      timer_q     <= '0;
      lfsr_q      <= 16'hACE1;
      score_q     <= 8'h00;
      pass_cnt_q  <= 4'd0;
      level_q     <= 5'd0;
      speed_q     <= 3'd1;
      gap_q       <= 10'd0;
      spawn_q     <= 1'b0;
      run_q       <= 1'b0;
      endgame_q   <= 1'b0;
      state_num_q <= 2'd0;
      digit_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      lfsr_q      <= lfsr_d;
      score_q     <= score_d;
      pass_cnt_q  <= pass_cnt_d;
      level_q     <= level_d;
      speed_q     <= speed_d;
      gap_q       <= gap_d;
      spawn_q     <= spawn_d;
      run_q       <= run_d;
      endgame_q   <= endgame_d;
      state_num_q <= state_num_d;
      digit_q     <= digit_d;
    end
  end

  // Next-state logic for the game flow and the output registers
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    score_d    = score_q;
    pass_cnt_d = pass_cnt_q;
    level_d    = level_q;
    speed_d    = speed_q;
    gap_d      = gap_q;
    spawn_d    = 1'b0;
    // Fibonacci LFSR, taps 16,14,13,11, free-running in every state
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    case (state_q)
      StIdle: begin
        if (start_rise) begin
          state_d    = StCountdown;
          score_d    = 8'h00;
          level_d    = 5'd0;
          pass_cnt_d = 4'd0;
          cnt_d      = CntW'(COUNTDOWN_FRAMES - 1);
        end
      end
      StCountdown: begin
        if (tick) begin
          speed_d = speed_tgt;
          if (cnt_q == '0) begin
            state_d = StPlay;
            timer_d = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      StPlay: begin
        if (tick) begin
          speed_d = speed_tgt;
          if (timer_q == '0) begin
            spawn_d = 1'b1;
            gap_d   = 10'(GAP_MIN) + {2'b00, lfsr_q[7:0]};
            timer_d = interval - 1'b1;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        // Collision outranks a simultaneous pipe_passed
        if (collision) begin
          state_d = StDying;
          cnt_d   = CntW'(DEATH_FRAMES - 1);
        end else if (pipe_passed && score_q != 8'h99) begin
          if (score_q[3:0] == 4'd9) begin
            score_d = {score_q[7:4] + 4'd1, 4'd0};
          end else begin
            score_d = {score_q[7:4], score_q[3:0] + 4'd1};
          end
          if (pass_cnt_q == 4'(SPEED_STEP_SCORE - 1)) begin
            pass_cnt_d = 4'd0;
            level_d    = level_q + 5'd1;
          end else begin
            pass_cnt_d = pass_cnt_q + 4'd1;
          end
        end
      end
      StDying: begin
        if (tick) begin
          if (cnt_q == '0) begin
            state_d = StOver;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      StOver: begin
        if (start_rise) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    run_d     = (state_d == StPlay);
    endgame_d = (state_d == StDying) || (state_d == StOver);
    case (state_d)
      StIdle:      state_num_d = 2'd0;
      StCountdown: state_num_d = 2'd1;
      StPlay:      state_num_d = 2'd2;
      default:     state_num_d = 2'd3;
    endcase
    digit_d = (state_d == StCountdown) ? 4'(cnt_d / 10'd60 + 10'd1) : 4'd0;
  end

  assign state_num       = state_num_q;
  assign frame_tick      = frame_tick_q;
  assign run             = run_q;
  assign endgame         = endgame_q;
  assign spawn           = spawn_q;
  assign spawn_gap_y     = gap_q;
  assign scroll_speed    = speed_q;
  assign countdown_digit = digit_q;
  assign score           = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: scripted vector table plus randomized play
// checked against a frame-level game model.
module tb_game_sequencer;

  localparam int CF   = 180;
  localparam int DF   = 60;
  localparam int SB   = 120;
  localparam int SS   = 16;
  localparam int GMIN = 80;
  localparam int SSS  = 5;
  localparam int MAXS = 4;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       start = 1'b0;
  logic       collision = 1'b0;
  logic       pipe_passed = 1'b0;
  logic [1:0] speed_sel = 2'd0;
  logic [1:0] state_num;
  logic       frame_tick, run, endgame, spawn;
  logic [9:0] spawn_gap_y;
  logic [2:0] scroll_speed;
  logic [3:0] countdown_digit;
  logic [7:0] score;

  always #10 Clk = ~Clk;

  game_sequencer dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .frame_clk       (frame_clk),
    .start           (start),
    .collision       (collision),
    .pipe_passed     (pipe_passed),
    .speed_sel       (speed_sel),
    .state_num       (state_num),
    .frame_tick      (frame_tick),
    .run             (run),
    .endgame         (endgame),
    .spawn           (spawn),
    .spawn_gap_y     (spawn_gap_y),
    .scroll_speed    (scroll_speed),
    .countdown_digit (countdown_digit),
    .score           (score)
  );

  int checks = 0;
  int failures = 0;
  int tick_cnt = 0;
  int spawn_cnt = 0;
  int spawn_total = 0;

  // Game model: 0 idle, 1 countdown, 2 play, 3 dying, 4 over
  int m_st, m_frames, m_pts, m_speed, m_play, m_next_spawn;

  // LFSR reference, advancing once per Clk from 16'hACE1
  logic [15:0] m_lfsr, m_lfsr_prev;
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_lfsr      <= 16'hACE1;
      m_lfsr_prev <= 16'hACE1;
    end else begin
      m_lfsr_prev <= m_lfsr;
      m_lfsr      <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  typedef struct {
    int sel; int passes; int frames;
    int st; int digit; int sc; int spd; int spawns;
  } vec_t;
  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  function automatic int spd_model();
    int s;
    s = 1 + int'(speed_sel) + m_pts / SSS;
    return (s > MAXS) ? MAXS : s;
  endfunction

  task automatic model_reset();
    m_st = 0; m_frames = 0; m_pts = 0; m_speed = 1; m_play = 0; m_next_spawn = 1;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    if (frame_tick === 1'b1) tick_cnt++;
    if (spawn === 1'b1) begin
      spawn_cnt++;
      spawn_total++;
      chk("spawn_gap_y", 32'(spawn_gap_y), 32'(GMIN + int'(m_lfsr_prev[7:0])));
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".state_num"}, 32'(state_num), (m_st >= 3) ? 3 : m_st);
    chk({tag, ".run"}, 32'(run), (m_st == 2) ? 1 : 0);
    chk({tag, ".endgame"}, 32'(endgame), (m_st >= 3) ? 1 : 0);
    chk({tag, ".digit"}, 32'(countdown_digit), (m_st == 1) ? 3 - m_frames / 60 : 0);
    chk({tag, ".score"}, 32'(score), bcd(m_pts));
    chk({tag, ".speed"}, 32'(scroll_speed), m_speed);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".state_num"}, 32'(state_num), 0);
    chk({tag, ".frame_tick"}, 32'(frame_tick), 0);
    chk({tag, ".run"}, 32'(run), 0);
    chk({tag, ".endgame"}, 32'(endgame), 0);
    chk({tag, ".spawn"}, 32'(spawn), 0);
    chk({tag, ".gap"}, 32'(spawn_gap_y), 0);
    chk({tag, ".speed"}, 32'(scroll_speed), 1);
    chk({tag, ".digit"}, 32'(countdown_digit), 0);
    chk({tag, ".score"}, 32'(score), 0);
  endtask

  task automatic do_frame();
    int exp_sp;
    exp_sp = 0;
    frame_clk = 1'b1;
    for (int i = 0; i < 6; i++) step();
    frame_clk = 1'b0;
    for (int i = 0; i < 3; i++) step();
    if (m_st == 1) begin
      m_frames++;
      m_speed = spd_model();
      if (m_frames == CF) begin
        m_st = 2; m_play = 0; m_next_spawn = 1;
      end
    end else if (m_st == 2) begin
      m_play++;
      if (m_play == m_next_spawn) begin
        exp_sp = 1;
        m_next_spawn = m_play + SB - SS * (m_speed - 1);
      end
      m_speed = spd_model();
    end else if (m_st == 3) begin
      m_frames++;
      if (m_frames == DF) m_st = 4;
    end
    chk("frame_tick_count", 32'(tick_cnt), 1);
    chk("spawn_count", 32'(spawn_cnt), 32'(exp_sp));
    check_outputs("frame");
    tick_cnt = 0;
    spawn_cnt = 0;
  endtask

  task automatic press_start();
    start = 1'b1;
    step();
    if (m_st == 0) begin
      m_st = 1; m_frames = 0; m_pts = 0;
    end else if (m_st == 4) begin
      m_st = 0;
    end
    check_outputs("start");
    start = 1'b0;
    step();
  endtask

  task automatic pass();
    pipe_passed = 1'b1;
    step();
    pipe_passed = 1'b0;
    if (m_st == 2 && m_pts < 99) m_pts++;
  endtask

  task automatic collide(input bit with_pass);
    collision = 1'b1;
    pipe_passed = with_pass;
    step();
    collision = 1'b0;
    pipe_passed = 1'b0;
    if (m_st == 2) begin
      m_st = 3; m_frames = 0;
    end
    check_outputs("collide");
  endtask

  initial begin
    int sp0;
    logic [7:0] held;
    //          sel pas frm st dg sc     spd spawns
    vecs[0]  = '{0, 0, 59, 1, 3, 'h00, 1, 0};
    vecs[1]  = '{0, 0, 1,  1, 2, 'h00, 1, 0};
    vecs[2]  = '{0, 0, 59, 1, 2, 'h00, 1, 0};
    vecs[3]  = '{0, 0, 1,  1, 1, 'h00, 1, 0};
    vecs[4]  = '{0, 0, 59, 1, 1, 'h00, 1, 0};
    vecs[5]  = '{0, 0, 1,  2, 0, 'h00, 1, 0};
    vecs[6]  = '{0, 0, 1,  2, 0, 'h00, 1, 1};
    vecs[7]  = '{0, 5, 60, 2, 0, 'h05, 2, 0};
    vecs[8]  = '{0, 0, 59, 2, 0, 'h05, 2, 0};
    vecs[9]  = '{0, 0, 1,  2, 0, 'h05, 2, 1};
    vecs[10] = '{0, 0, 103, 2, 0, 'h05, 2, 0};
    vecs[11] = '{0, 0, 1,  2, 0, 'h05, 2, 1};
    vecs[12] = '{0, 4, 0,  2, 0, 'h09, 2, 0};
    vecs[13] = '{0, 1, 0,  2, 0, 'h10, 2, 0};
    vecs[14] = '{0, 0, 1,  2, 0, 'h10, 3, 0};
    vecs[15] = '{3, 0, 1,  2, 0, 'h10, 4, 0};
    vecs[16] = '{3, 89, 0, 2, 0, 'h99, 4, 0};
    vecs[17] = '{3, 30, 0, 2, 0, 'h99, 4, 0};

    model_reset();
    // Reset with the start key held throughout
    start = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_reset("in_reset");
    #5 Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("held_start.state_num", 32'(state_num), 0);
    start = 1'b0;
    step();

    // Frame tick latency: three Clk edges after VS rises, one Clk wide
    frame_clk = 1'b1;
    step(); chk("tick_lat1", 32'(frame_tick), 0);
    step(); chk("tick_lat2", 32'(frame_tick), 0);
    step(); chk("tick_lat3", 32'(frame_tick), 1);
    step(); chk("tick_lat4", 32'(frame_tick), 0);
    frame_clk = 1'b0;
    for (int i = 0; i < 3; i++) step();
    tick_cnt = 0;
    spawn_cnt = 0;

    // Game 1: scripted vectors
    press_start();
    for (int i = 0; i < 18; i++) begin
      speed_sel = 2'(vecs[i].sel);
      sp0 = spawn_total;
      for (int p = 0; p < vecs[i].passes; p++) pass();
      for (int f = 0; f < vecs[i].frames; f++) do_frame();
      chk($sformatf("vec%0d.state", i), 32'(state_num), 32'(vecs[i].st));
      chk($sformatf("vec%0d.digit", i), 32'(countdown_digit), 32'(vecs[i].digit));
      chk($sformatf("vec%0d.score", i), 32'(score), 32'(vecs[i].sc));
      chk($sformatf("vec%0d.speed", i), 32'(scroll_speed), 32'(vecs[i].spd));
      chk($sformatf("vec%0d.spawns", i), 32'(spawn_total - sp0), 32'(vecs[i].spawns));
      check_outputs($sformatf("vec%0d", i));
    end

    // Death sequence; start is ignored while dying, honoured in OVER
    collide(1'b0);
    for (int f = 0; f < DF - 1; f++) do_frame();
    press_start();
    do_frame();
    chk("over.endgame", 32'(endgame), 1);
    chk("over.score_held", 32'(score), 'h99);
    press_start();
    chk("over_to_idle.state", 32'(state_num), 0);

    // Game 2: randomized play against the model
    speed_sel = 2'($urandom_range(0, 3));
    press_start();
    for (int f = 0; f < CF; f++) do_frame();
    for (int f = 0; f < 300; f++) begin
      if ($urandom_range(0, 7) == 0) speed_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) pass();
      do_frame();
    end
    held = score;
    collide(1'b1);
    chk("coll_pass.score", 32'(score), 32'(held));
    chk("coll_pass.endgame", 32'(endgame), 1);
    chk("coll_pass.run", 32'(run), 0);
    for (int f = 0; f < DF; f++) do_frame();
    press_start();

    // Game 3: asynchronous reset in the middle of PLAY
    speed_sel = 2'd1;
    press_start();
    for (int f = 0; f < CF; f++) do_frame();
    for (int f = 0; f < 40; f++) begin
      if (f % 4 == 0) pass();
      do_frame();
    end
    chk("pre_reset.run", 32'(run), 1);
    #4 Reset_n = 1'b0;
    #1;
    check_reset("async_reset");
    model_reset();
    step();
    #7 Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("post_reset.state", 32'(state_num), 0);
    check_outputs("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
